// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into
// words and writes them to the instruction RAM, holding the core while busy.
module imem_loader #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32,
  localparam int AW = $clog2(TAM_POSICIONES)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [AW:0]            WORD_COUNT,
  input  logic                   ABORT,
  input  logic [7:0]             BYTE_IN,
  input  logic                   BYTE_VALID,
  output logic                   BYTE_READY,
  output logic                   WR_EN,
  output logic [AW-1:0]          WR_ADDRESS,
  output logic [TAM_PALABRA-1:0] WR_DATA,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int BPW = TAM_PALABRA / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW:0] CAP = (AW+1)'(TAM_POSICIONES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FINISH
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [AW-1:0]          addr_q;
  logic [AW:0]            cnt_q;
  logic [AW:0]            words_q;
  logic [TAM_PALABRA-1:0] word_q;

  logic [TAM_PALABRA-1:0] word_d;
  logic [AW:0]            cnt_d;
  logic [AW:0]            words_d;
  logic                   xfer;
  logic                   last_byte;

  assign xfer      = BYTE_VALID & BYTE_READY;
  assign last_byte = (idx_q == IW'(BPW - 1));
  assign cnt_d     = (WORD_COUNT > CAP) ? CAP : WORD_COUNT;
  assign words_d   = words_q + (AW+1)'(1);

  // Incoming byte lands in its little-endian lane of the word
  always_comb begin
    word_d = word_q;
    word_d[{idx_q, 3'b000} +: 8] = BYTE_IN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      words_q    <= '0;
      word_q     <= '0;
      BYTE_READY <= 1'b0;
      WR_EN      <= 1'b0;
      WR_ADDRESS <= '0;
      WR_DATA    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      DONE  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!ABORT && START) begin
            if (WORD_COUNT == '0) begin
              state_q <= FINISH;
              DONE    <= 1'b1;
            end else begin
              cnt_q      <= cnt_d;
              addr_q     <= '0;
              idx_q      <= '0;
              words_q    <= '0;
              state_q    <= COLLECT;
              BYTE_READY <= 1'b1;
              BUSY       <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (ABORT) begin
            state_q    <= IDLE;
            BYTE_READY <= 1'b0;
            BUSY       <= 1'b0;
          end else if (xfer) begin
            word_q <= word_d;
            if (last_byte) begin
              state_q    <= WRITE;
              BYTE_READY <= 1'b0;
              WR_EN      <= 1'b1;
              WR_ADDRESS <= addr_q;
              WR_DATA    <= word_d;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        WRITE: begin
          addr_q  <= addr_q + AW'(1);
          words_q <= words_d;
          idx_q   <= '0;
          if (ABORT) begin
            state_q <= IDLE;
            BUSY    <= 1'b0;
          end else if (words_d == cnt_q) begin
            state_q <= FINISH;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
          end else begin
            state_q    <= COLLECT;
            BYTE_READY <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          BYTE_READY <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and matched against each WR_EN strobe.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int AW = 10;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic [AW:0]   WORD_COUNT;
  logic          ABORT;
  logic [7:0]    BYTE_IN;
  logic          BYTE_VALID;
  logic          BYTE_READY;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDRESS;
  logic [31:0]   WR_DATA;
  logic          BUSY;
  logic          DONE;

  imem_loader #(
    .TAM_POSICIONES(1024),
    .TAM_PALABRA(32)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .WORD_COUNT(WORD_COUNT),
    .ABORT(ABORT),
    .BYTE_IN(BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY),
    .WR_EN(WR_EN),
    .WR_ADDRESS(WR_ADDRESS),
    .WR_DATA(WR_DATA),
    .BUSY(BUSY),
    .DONE(DONE)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int last_wr_cyc = 0;
  bit lat_chk = 0;
  bit stuck = 0;

  logic [41:0] sb[$];
  logic [31:0] words[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (RST_N && BYTE_VALID && BYTE_READY) acc_cnt++;
  end

  always @(negedge CLK) begin
    if (WR_EN) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        chk("wr_unexp", {54'd0, WR_ADDRESS}, 64'hdead);
      end else begin
        logic [41:0] e;
        e = sb.pop_front();
        chk("wr_addr", 64'(WR_ADDRESS), 64'(e[41:32]));
        chk("wr_data", 64'(WR_DATA), 64'(e[31:0]));
        chk("wr_busy", 64'(BUSY), 64'd1);
      end
    end
    if (DONE) begin
      done_cnt++;
      chk("done_busy", 64'(BUSY), 64'd0);
      if (lat_chk) chk("done_lat", 64'(cyc - last_wr_cyc), 64'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic start(input int c);
    @(negedge CLK);
    START = 1'b1;
    WORD_COUNT = (AW+1)'(c);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (stuck) return;
    if (gap) begin
      BYTE_VALID = 1'b0;
      @(negedge CLK);
    end
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    n = 0;
    while (!BYTE_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!BYTE_READY) begin
      chk("ready_timeout", 64'(BYTE_READY), 64'd1);
      stuck = 1;
    end
    @(negedge CLK);
  endtask

  task automatic send_word(input int a, input logic [31:0] w, input bit gap,
                           input bit push);
    if (push) sb.push_back({a[9:0], w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n;
    n = 0;
    while (done_cnt == prev && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("done_seen", 64'(done_cnt - prev), 64'd1);
  endtask

  task automatic run_load(input int cnt, input bit gap);
    int d0;
    int a0;
    d0 = done_cnt;
    a0 = acc_cnt;
    start(cnt);
    chk("busy_after_start", 64'(BUSY), 64'd1);
    for (int i = 0; i < words.size(); i++) send_word(i, words[i], gap, 1'b1);
    BYTE_VALID = 1'b0;
    wait_done(d0, 200);
    chk("bytes_accepted", 64'(acc_cnt - a0), 64'(4 * words.size()));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w0;
    int d0;
    RST_N = 1'b0;
    START = 1'b0;
    WORD_COUNT = '0;
    ABORT = 1'b0;
    BYTE_IN = '0;
    BYTE_VALID = 1'b0;
    #1;
    chk("rst_ready", 64'(BYTE_READY), 64'd0);
    chk("rst_wren", 64'(WR_EN), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_addr", 64'(WR_ADDRESS), 64'd0);
    chk("rst_data", 64'(WR_DATA), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // two words back-to-back
    lat_chk = 1;
    words = '{32'h00000013, 32'h00100093};
    run_load(2, 1'b0);
    chk("t1_writes", 64'(wr_cnt), 64'd2);
    chk("t1_hold_addr", 64'(WR_ADDRESS), 64'd1);
    chk("t1_hold_data", 64'(WR_DATA), 64'h00100093);
    chk("t1_idle_ready", 64'(BYTE_READY), 64'd0);

    // same load, source toggling valid
    run_load(2, 1'b1);
    chk("t2_writes", 64'(wr_cnt), 64'd4);

    // zero-length load
    lat_chk = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    start(0);
    chk("t3_done", 64'(DONE), 64'd1);
    chk("t3_busy", 64'(BUSY), 64'd0);
    @(negedge CLK);
    chk("t3_done_pulse", 64'(DONE), 64'd0);
    chk("t3_busy2", 64'(BUSY), 64'd0);
    chk("t3_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // oversize count clamps to the memory depth
    lat_chk = 1;
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back($urandom);
    w0 = wr_cnt;
    run_load(1025, 1'b0);
    chk("t4_writes", 64'(wr_cnt - w0), 64'd1024);
    chk("t4_last_addr", 64'(WR_ADDRESS), 64'd1023);
    @(negedge CLK);
    chk("t4_ready_after", 64'(BYTE_READY), 64'd0);

    // abort after two bytes of word 1
    lat_chk = 0;
    d0 = done_cnt;
    w0 = wr_cnt;
    start(3);
    send_word(0, 32'hcafe0001, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    BYTE_VALID = 1'b0;
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    chk("t5_busy", 64'(BUSY), 64'd0);
    chk("t5_ready", 64'(BYTE_READY), 64'd0);
    repeat (4) @(negedge CLK);
    chk("t5_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    lat_chk = 1;
    words = '{32'h12345678};
    run_load(1, 1'b0);
    chk("t5_reload_addr", 64'(WR_ADDRESS), 64'd0);

    // reset after three bytes of word 0
    lat_chk = 0;
    w0 = wr_cnt;
    d0 = done_cnt;
    start(2);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    send_byte(8'hcc, 1'b0);
    BYTE_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("t6_busy", 64'(BUSY), 64'd0);
    chk("t6_ready", 64'(BYTE_READY), 64'd0);
    chk("t6_data", 64'(WR_DATA), 64'd0);
    chk("t6_wren", 64'(WR_EN), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t6_no_write", 64'(wr_cnt - w0), 64'd0);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    lat_chk = 1;
    words = '{32'hdeadbeef, 32'h0badf00d};
    run_load(2, 1'b1);
    chk("t6_after_addr", 64'(WR_ADDRESS), 64'd1);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side companion to the asynchronous instruction ROM. The loader fills the instruction memory image at run time so the core does not rely on a file preload. It accepts a byte stream through a valid/ready handshake and assembles bytes little-endian into TAM_PALABRA-bit words. Each completed word produces one single-cycle write strobe to the instruction RAM, starting at address 0. The loader sits between a host byte source (UART receiver or testbench) and the write port of the instruction memory, and holds the core in reset while loading.

Parameters:
TAM_POSICIONES, 1024, number of instruction memory words; address width AW = $clog2(TAM_POSICIONES)
TAM_PALABRA, 32, word width in bits; must be a multiple of 8; BPW = TAM_PALABRA/8 bytes per word

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  single-cycle request to begin a load; sampled only in IDLE
WORD_COUNT  in  AW+1  number of words to load; sampled with START
ABORT  in  1  synchronous abort; returns the loader to IDLE
BYTE_IN  in  8  incoming byte
BYTE_VALID  in  1  BYTE_IN is valid
BYTE_READY  out  1  loader accepts a byte this cycle
WR_EN  out  1  instruction memory write strobe
WR_ADDRESS  out  AW  word address for the write
WR_DATA  out  TAM_PALABRA  assembled word
BUSY  out  1  load in progress; drives the core hold/reset
DONE  out  1  single-cycle pulse when a load completes normally

Behaviour:
- All outputs are registered.
- Reset (RST_N=0, asynchronous): state IDLE. BYTE_READY, WR_EN, BUSY and DONE are 0. WR_ADDRESS and WR_DATA are 0. Byte index, word counter and latched count are 0.
- Reset mid-load aborts immediately. The partial word is discarded and no WR_EN is issued.
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - START=1 and WORD_COUNT=0: go to FINISH. DONE is 1 on the next cycle and no write occurs.
  - START=1 and WORD_COUNT>0: latch count = min(WORD_COUNT, TAM_POSICIONES), clear the address and byte index, go to COLLECT.
- COLLECT:
  - BYTE_READY=1 and BUSY=1.
  - A byte transfers only in a cycle with BYTE_VALID=1 and BYTE_READY=1.
  - Byte k of a word (k = 0..BPW-1) is stored at bits [8k+7:8k]; the first byte is the LSB.
  - When byte BPW-1 transfers, go to WRITE. BYTE_READY drops to 0 in that same next cycle, so no byte is lost.
- WRITE:
  - Lasts exactly one cycle with WR_EN=1, WR_ADDRESS = current address and WR_DATA = assembled word.
  - The following cycle increments the address and word counter.
  - If the words written equal the latched count, go to FINISH; otherwise return to COLLECT with byte index 0.
- FINISH: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Timing: last byte accepted in cycle N gives WR_EN in N+1. If that was the last word, DONE is in N+2.
- Minimum per word is BPW+1 cycles.
- Outside the WRITE state:
  - WR_EN=0.
  - WR_ADDRESS and WR_DATA hold their last written values.
- START outside IDLE is ignored. WORD_COUNT is only sampled with START.
- ABORT=1 in COLLECT or WRITE:
  - Next state is IDLE, BUSY falls and DONE is not pulsed.
  - ABORT in the WRITE cycle still lets that cycle's WR_EN (already registered) complete; no further write occurs.
  - ABORT has priority over START.
- Address wrap: cannot occur, because the count is clamped to TAM_POSICIONES. The final address is count-1.
- A stalled source (BYTE_VALID=0) simply holds COLLECT indefinitely. There is no timeout.

Test Plan:
- Reset, then START with WORD_COUNT=2 and bytes 13,00,00,00,93,00,10,00 sent back-to-back. Required: WR_EN at addr 0 with data 00000013, then addr 1 with data 00100093. DONE one cycle after the second write. BUSY is 1 from the cycle after START until DONE.
- Same load with BYTE_VALID toggling every other cycle. Required: identical writes, and no byte is accepted while BYTE_READY=0.
- START with WORD_COUNT=0. Required: DONE pulse one cycle later, WR_EN never asserted, BUSY stays 0.
- START with WORD_COUNT=1025 (TAM_POSICIONES=1024) and 4096 bytes. Required: exactly 1024 writes at addresses 0..1023, then DONE; BYTE_READY=0 afterwards.
- ABORT after 2 bytes of word 1 (WORD_COUNT=3). Required: one write only (addr 0), IDLE next cycle, no DONE. A new START reloads from addr 0.
- RST_N low for one cycle after 3 bytes of word 0. Required: all outputs return to 0 asynchronously and no WR_EN appears. A subsequent START operates normally.
